// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex-to-segment table for the seg7 scan scheduler.
//  seg7_state_t : scan scheduler FSM states
//  seg7_t       : active-low segment byte {dp,g,f,e,d,c,b,a}
//  seg7_encode  : 4-bit hex -> seg7_t, decimal point off
package seg7_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } seg7_state_t;

    typedef logic [7:0] seg7_t;

    localparam seg7_t       SEG7_BLANK      = 8'hFF;
    localparam int unsigned SEG7_NUM_DIGITS = 6;

    // Active-low glyphs; bit 7 (dp) is always 1 (off) here.
    function automatic seg7_t seg7_encode(input logic [3:0] hex);
        seg7_t seg;
        case (hex)
            4'h0:    seg = 8'hC0;
            4'h1:    seg = 8'hF9;
            4'h2:    seg = 8'hA4;
            4'h3:    seg = 8'hB0;
            4'h4:    seg = 8'h99;
            4'h5:    seg = 8'h92;
            4'h6:    seg = 8'h82;
            4'h7:    seg = 8'hF8;
            4'h8:    seg = 8'h80;
            4'h9:    seg = 8'h98;
            4'hA:    seg = 8'h88;
            4'hB:    seg = 8'h83;
            4'hC:    seg = 8'hA7;
            4'hD:    seg = 8'hA1;
            4'hE:    seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low 7-segment decoder.
//  hex_i : 4-bit nibble
//  seg_o : segments {dp,g,f,e,d,c,b,a}, dp off
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] hex_i,
    output seg7_t      seg_o
);

    assign seg_o = seg7_encode(hex_i);

endmodule

// File: rtl/seg7_scan_scheduler.sv
// Time-shares one hex decoder across six display digits. A LOAD captures the
// value, the digits are decoded one per clock (HEX5 down to HEX0) into a
// staging bank, and the bank is committed to the display in one cycle.
// Adds leading-zero blanking, per-digit decimal point and blink.
//  CLK1        : clock, posedge
//  RST_N       : synchronous active-low reset
//  VALUE/DP    : six nibbles / six decimal points, index n -> HEXn
//  LOAD        : one-cycle display request (queued as pending while busy)
//  BLANK_LZ_EN : blank leading zero digits (HEX0 never blanked)
//  BLINK_MASK  : per-digit blink enable
//  BUSY        : scan or commit in progress
//  DONE        : one-cycle pulse on the edge the display updates
//  HEX0..HEX5  : active-low segments {dp,g,f,e,d,c,b,a}
module seg7_scan_scheduler
    import seg7_pkg::*;
#(
    parameter int unsigned P_BLINK_DIV = 25_000_000
) (
    input  logic        CLK1,
    input  logic        RST_N,
    input  logic [23:0] VALUE,
    input  logic [5:0]  DP,
    input  logic        LOAD,
    input  logic        BLANK_LZ_EN,
    input  logic [5:0]  BLINK_MASK,
    output logic        BUSY,
    output logic        DONE,
    output logic [7:0]  HEX0,
    output logic [7:0]  HEX1,
    output logic [7:0]  HEX2,
    output logic [7:0]  HEX3,
    output logic [7:0]  HEX4,
    output logic [7:0]  HEX5
);

    localparam int unsigned NUM_DIG = SEG7_NUM_DIGITS;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned PRE_W   = (P_BLINK_DIV > 2) ? $clog2(P_BLINK_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_DIG - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(P_BLINK_DIV - 1);

    seg7_state_t       state_q;
    logic [IDX_W-1:0]  idx_q;
    logic              lz_q;
    logic [23:0]       value_q;
    logic [5:0]        dp_q;
    logic              lz_en_q;
    logic              pending_q;
    logic [23:0]       pend_value_q;
    logic [5:0]        pend_dp_q;
    logic              pend_lz_en_q;
    logic              busy_q;
    logic              done_q;
    seg7_t             stage_q [NUM_DIG];
    seg7_t             disp_q  [NUM_DIG];
    logic [PRE_W-1:0]  presc_q;
    logic              blink_q;

    logic [3:0]        nibble_d;
    seg7_t             seg_d;
    logic              blank_d;
    seg7_t             stage_d;

    // Shared decoder: the current scan index selects the nibble.
    assign nibble_d = value_q[{idx_q, 2'b00} +: 4];

    seg7_hex_decoder u_dec (
        .hex_i (nibble_d),
        .seg_o (seg_d)
    );

    // Decoded glyph dp bit is always 1, so ANDing with ~DP sets the dp cleanly.
    assign blank_d = lz_en_q && lz_q && (nibble_d == 4'h0) && (idx_q != '0);
    assign stage_d = (blank_d ? SEG7_BLANK : seg_d) & {~dp_q[idx_q], 7'h7F};

    // Scan/commit FSM, request queueing and free-running blink prescaler.
    always_ff @(posedge CLK1) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            lz_q         <= 1'b0;
            value_q      <= '0;
            dp_q         <= '0;
            lz_en_q      <= 1'b0;
            pending_q    <= 1'b0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_lz_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            presc_q      <= '0;
            blink_q      <= 1'b0;
            for (int i = 0; i < NUM_DIG; i++) begin
                stage_q[i] <= SEG7_BLANK;
                disp_q[i]  <= SEG7_BLANK;
            end
        end else begin
            done_q <= 1'b0;

            if (presc_q == PRE_LAST) begin
                presc_q <= '0;
                blink_q <= ~blink_q;
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (LOAD) begin
                        value_q <= VALUE;
                        dp_q    <= DP;
                        lz_en_q <= BLANK_LZ_EN;
                        idx_q   <= IDX_TOP;
                        lz_q    <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= S_SCAN;
                    end
                end

                S_SCAN: begin
                    stage_q[idx_q] <= stage_d;
                    if (!blank_d) begin
                        lz_q <= 1'b0;
                    end
                    if (LOAD) begin
                        pending_q    <= 1'b1;
                        pend_value_q <= VALUE;
                        pend_dp_q    <= DP;
                        pend_lz_en_q <= BLANK_LZ_EN;
                    end
                    if (idx_q == '0) begin
                        state_q <= S_COMMIT;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end

                S_COMMIT: begin
                    for (int i = 0; i < NUM_DIG; i++) begin
                        disp_q[i] <= stage_q[i];
                    end
                    done_q <= 1'b1;
                    // A LOAD arriving in this cycle supersedes any older pending copy.
                    if (LOAD || pending_q) begin
                        value_q   <= LOAD ? VALUE : pend_value_q;
                        dp_q      <= LOAD ? DP : pend_dp_q;
                        lz_en_q   <= LOAD ? BLANK_LZ_EN : pend_lz_en_q;
                        pending_q <= 1'b0;
                        idx_q     <= IDX_TOP;
                        lz_q      <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_SCAN;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;

    // Blink gating is flop-to-pin only; no decode logic in this path.
    assign HEX0 = (blink_q && BLINK_MASK[0]) ? SEG7_BLANK : disp_q[0];
    assign HEX1 = (blink_q && BLINK_MASK[1]) ? SEG7_BLANK : disp_q[1];
    assign HEX2 = (blink_q && BLINK_MASK[2]) ? SEG7_BLANK : disp_q[2];
    assign HEX3 = (blink_q && BLINK_MASK[3]) ? SEG7_BLANK : disp_q[3];
    assign HEX4 = (blink_q && BLINK_MASK[4]) ? SEG7_BLANK : disp_q[4];
    assign HEX5 = (blink_q && BLINK_MASK[5]) ? SEG7_BLANK : disp_q[5];

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Self-checking bench for seg7_scan_scheduler (P_BLINK_DIV = 4).
module tb_seg7_scan_scheduler;

    localparam int unsigned BLINK_DIV = 4;

    logic        CLK1 = 1'b0;
    logic        RST_N;
    logic [23:0] VALUE;
    logic [5:0]  DP;
    logic        LOAD;
    logic        BLANK_LZ_EN;
    logic [5:0]  BLINK_MASK;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;

    int n_vec  = 0;
    int n_miss = 0;
    int k_edges = 0;

    seg7_scan_scheduler #(.P_BLINK_DIV(BLINK_DIV)) dut (
        .CLK1        (CLK1),
        .RST_N       (RST_N),
        .VALUE       (VALUE),
        .DP          (DP),
        .LOAD        (LOAD),
        .BLANK_LZ_EN (BLANK_LZ_EN),
        .BLINK_MASK  (BLINK_MASK),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .HEX0        (HEX0),
        .HEX1        (HEX1),
        .HEX2        (HEX2),
        .HEX3        (HEX3),
        .HEX4        (HEX4),
        .HEX5        (HEX5)
    );

    always #5 CLK1 = ~CLK1;

    // Edges since the last reset edge; blink phase is (k / DIV) % 2.
    always @(posedge CLK1) k_edges <= RST_N ? k_edges + 1 : 0;

    typedef struct {
        logic [23:0] value;
        logic [5:0]  dp;
        logic        lz;
        logic [47:0] exp;   // {HEX5..HEX0}
    } vec_t;

    vec_t tbl[9];

    function automatic logic [7:0] glyph(input logic [3:0] h);
        logic [7:0] t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hA7, 8'hA1, 8'h86, 8'h8E};
        return t[h];
    endfunction

    // Reference: digit n blanks when every nibble from n upward is zero.
    function automatic logic [47:0] model(input logic [23:0] v, input logic [5:0] dp,
                                          input logic lz);
        logic [47:0] r;
        logic [7:0]  d;
        for (int n = 0; n < 6; n++) begin
            if (lz && n != 0 && (v >> (4 * n)) == 24'h0) d = 8'hFF;
            else d = glyph(4'((v >> (4 * n)) & 24'hF));
            if (dp[n]) d[7] = 1'b0;
            r[8*n +: 8] = d;
        end
        return r;
    endfunction

    function automatic logic [47:0] hex_all();
        return {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [23:0] v, input logic [5:0] d, input logic l);
        @(negedge CLK1);
        VALUE = v; DP = d; BLANK_LZ_EN = l; LOAD = 1'b1;
        @(negedge CLK1);
        LOAD = 1'b0;
    endtask

    // Negedges until DONE is seen, -1 on timeout.
    task automatic wait_done(output int cyc);
        bit got = 0;
        cyc = 0;
        while (!got && cyc < 40) begin
            @(negedge CLK1);
            cyc++;
            if (DONE) got = 1;
        end
        if (!got) cyc = -1;
    endtask

    initial begin
        int cyc;
        int pulses;
        int first_at;
        int second_at;
        bit saw_ones;
        logic [23:0] rv;
        logic [5:0]  rdp;
        logic        rlz;

        tbl[0] = '{24'h012345, 6'b000000, 1'b1, 48'hFF_F9_A4_B0_99_92};
        tbl[1] = '{24'h000000, 6'b000000, 1'b1, 48'hFF_FF_FF_FF_FF_C0};
        tbl[2] = '{24'h000000, 6'b000000, 1'b0, 48'hC0_C0_C0_C0_C0_C0};
        tbl[3] = '{24'h100000, 6'b000000, 1'b1, 48'hF9_C0_C0_C0_C0_C0};
        tbl[4] = '{24'h000123, 6'b000100, 1'b1, 48'hFF_FF_FF_79_A4_B0};
        tbl[5] = '{24'h000023, 6'b000100, 1'b1, 48'hFF_FF_FF_7F_A4_B0};
        tbl[6] = '{24'hABCDEF, 6'b111111, 1'b0, 48'h08_03_27_21_06_0E};
        tbl[7] = '{24'h000000, 6'b100001, 1'b1, 48'h7F_FF_FF_FF_FF_40};
        tbl[8] = '{24'h987600, 6'b000000, 1'b1, 48'h98_80_F8_82_C0_C0};

        RST_N = 1'b0; VALUE = '0; DP = '0; LOAD = 1'b0;
        BLANK_LZ_EN = 1'b0; BLINK_MASK = '0;
        repeat (3) @(negedge CLK1);
        LOAD = 1'b1;
        @(negedge CLK1);
        LOAD = 1'b0;
        RST_N = 1'b1;
        chk("reset_hex", hex_all(), {6{8'hFF}});
        chk("reset_busy", 48'(BUSY), 48'd0);
        chk("reset_done", 48'(DONE), 48'd0);

        // Table vectors, with latency and BUSY/DONE shape on each.
        for (int i = 0; i < 9; i++) begin
            do_load(tbl[i].value, tbl[i].dp, tbl[i].lz);
            chk($sformatf("busy_t1[%0d]", i), 48'(BUSY), 48'd1);
            wait_done(cyc);
            chk($sformatf("latency[%0d]", i), 48'(cyc), 48'd7);
            chk($sformatf("busy_t7[%0d]", i), 48'(BUSY), 48'd0);
            chk($sformatf("table[%0d]", i), hex_all(), tbl[i].exp);
            @(negedge CLK1);
            chk($sformatf("done_pulse[%0d]", i), 48'(DONE), 48'd0);
        end

        // Random loads against the reference model.
        for (int i = 0; i < 30; i++) begin
            rv  = 24'($urandom) >> (4 * $urandom_range(0, 6));
            rdp = 6'($urandom);
            rlz = 1'($urandom_range(0, 1));
            do_load(rv, rdp, rlz);
            wait_done(cyc);
            chk($sformatf("rand_lat[%0d]", i), 48'(cyc), 48'd7);
            chk($sformatf("rand[%0d] v=%h dp=%b lz=%0d", i, rv, rdp, rlz),
                hex_all(), model(rv, rdp, rlz));
        end

        // Requests while busy: latest pending wins, two commits total.
        do_load(24'hAAAAAA, 6'b0, 1'b0);               // position 0 = edge t
        do_load(24'h111111, 6'b0, 1'b0);               // sampled at t+2
        do_load(24'hFFFFFF, 6'b0, 1'b0);               // sampled at t+4
        pulses = 0; first_at = -1; second_at = -1; saw_ones = 0;
        for (int p = 5; p <= 20; p++) begin
            @(negedge CLK1);
            if (HEX0 == 8'hF9) saw_ones = 1;
            if (p == 7) begin
                chk("coalesce_first", hex_all(), {6{8'h88}});
                chk("coalesce_busy_t7", 48'(BUSY), 48'd1);
            end
            if (DONE) begin
                pulses++;
                if (first_at < 0) first_at = p;
                else if (second_at < 0) second_at = p;
            end
        end
        chk("coalesce_pulses", 48'(pulses), 48'd2);
        chk("coalesce_first_at", 48'(first_at), 48'd7);
        chk("coalesce_second_at", 48'(second_at), 48'd14);
        chk("coalesce_final", hex_all(), {6{8'h8E}});
        chk("coalesce_no_ones", 48'(saw_ones), 48'd0);
        chk("coalesce_idle", 48'(BUSY), 48'd0);

        // Blink on HEX0 only.
        do_load(24'h000005, 6'b0, 1'b0);
        wait_done(cyc);
        chk("blink_lat", 48'(cyc), 48'd7);
        BLINK_MASK = 6'b000001;
        for (int p = 0; p < 16; p++) begin
            @(negedge CLK1);
            chk($sformatf("blink_hex0[%0d]", p), 48'(HEX0),
                ((k_edges / BLINK_DIV) % 2 == 1) ? 48'hFF : 48'h92);
            chk($sformatf("blink_steady[%0d]", p), {8'h0, HEX5, HEX4, HEX3, HEX2, HEX1},
                {8'h0, {5{8'hC0}}});
        end
        BLINK_MASK = 6'b000000;

        // Reset in the middle of a scan.
        do_load(24'h012345, 6'b0, 1'b1);               // position 0
        @(negedge CLK1);                               // position 1
        @(negedge CLK1);                               // position 2
        RST_N = 1'b0;
        @(negedge CLK1);                               // after edge t+3
        chk("midreset_hex", hex_all(), {6{8'hFF}});
        chk("midreset_busy", 48'(BUSY), 48'd0);
        chk("midreset_done", 48'(DONE), 48'd0);
        RST_N = 1'b1;
        pulses = 0;
        for (int p = 0; p < 12; p++) begin
            @(negedge CLK1);
            if (DONE) pulses++;
        end
        chk("midreset_no_done", 48'(pulses), 48'd0);
        chk("midreset_dark", hex_all(), {6{8'hFF}});
        do_load(24'h012345, 6'b0, 1'b1);
        wait_done(cyc);
        chk("postreset_lat", 48'(cyc), 48'd7);
        chk("postreset_hex", hex_all(), 48'hFF_F9_A4_B0_99_92);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
